mem_burst_reader: RTL and testbench

MEM_BURST_READER -- requirements
Module: mem_burst_reader

---
 rtl/mem_burst_pkg.sv | 13 +
 rtl/mem_burst_fifo.sv | 80 ++++++++
 rtl/mem_burst_reader.sv | 128 ++++++++++++
 tb/tb_mem_burst_reader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_burst_pkg.sv
// Shared definitions for the burst reader: FSM state encoding and FIFO depth.
package mem_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Number of read words that may be buffered or in flight at once.
  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/mem_burst_fifo.sv
// Two-entry output FIFO. The head entry drives the consumer interface
// directly from registers; the tail entry absorbs one word of backpressure.
module mem_burst_fifo
  import mem_burst_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [1:0]        count
);

  logic              tail_valid;
  logic [DATA_W-1:0] tail_data;
  logic              tail_last;
  logic              take;

  // Handshake decode and occupancy reported to the read scheduler.
  always_comb begin
    take  = out_valid & ready;
    count = {1'b0, out_valid} + {1'b0, tail_valid};
  end

  // Head/tail update; the scheduler never pushes into a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      tail_valid <= 1'b0;
      tail_data  <= '0;
      tail_last  <= 1'b0;
    end else begin
      case ({push, take})
        2'b10: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= push_data;
            out_last  <= push_last;
          end else begin
            tail_valid <= 1'b1;
            tail_data  <= push_data;
            tail_last  <= push_last;
          end
        end
        2'b01: begin
          if (tail_valid) begin
            out_data   <= tail_data;
            out_last   <= tail_last;
            tail_valid <= 1'b0;
          end else begin
            out_valid <= 1'b0;
          end
        end
        2'b11: begin
          if (tail_valid) begin
            out_data  <= tail_data;
            out_last  <= tail_last;
            tail_data <= push_data;
            tail_last <= push_last;
          end else begin
            out_data <= push_data;
            out_last <= push_last;
          end
        end
        default: begin
          out_valid <= out_valid;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_burst_reader.sv
// Byte-writable word memory with a burst read engine. A burst streams
// consecutive words (wrapping at the top of the array) through a 2-entry
// FIFO to a valid/ready consumer.
module mem_burst_reader
  import mem_burst_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0] wr_en,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   start_len,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LANES = DATA_W / 8;
  localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [2:0]      CREDITS  = 3'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   remaining;
  logic              in_flight;
  logic              in_flight_last;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        fifo_count;
  logic [2:0]        credit;
  logic              pop;
  logic              issue;
  logic              last_issue;

  // Read scheduling: a slot freed by this edge's pop may be reused at once,
  // which keeps a one-word-per-cycle stream when the consumer never stalls.
  always_comb begin
    pop        = out_valid & out_ready;
    credit     = {1'b0, fifo_count} + {2'b0, in_flight};
    last_issue = (remaining == (ADDR_W+1)'(1));
    if (state == ST_RUN) begin
      issue = (credit < CREDITS) || ((credit == CREDITS) && pop);
    end else begin
      issue = 1'b0;
    end
  end

  // Memory array: per-lane writes every cycle; the read sees the pre-write word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i]) begin
        mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    if (issue) begin
      rd_data <= mem[rd_addr];
    end
  end

  // Burst control FSM, read address/length tracking and in-flight bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      rd_addr        <= '0;
      remaining      <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      in_flight      <= issue;
      in_flight_last <= issue & last_issue;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            busy      <= 1'b1;
            rd_addr   <= start_addr;
            remaining <= (start_len == '0) ? FULL_LEN : {1'b0, start_len};
          end
        end
        ST_RUN: begin
          if (issue) begin
            rd_addr   <= rd_addr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
            if (last_issue) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && out_last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  mem_burst_fifo #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_flight),
    .push_data (rd_data),
    .push_last (in_flight_last),
    .ready     (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_mem_burst_reader.sv
// Self-checking bench for mem_burst_reader: directed vector table, hand-written
// corner sequences and randomized bursts against a word-array reference model.
module tb_mem_burst_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_en;
  logic [31:0] wr_data;
  logic        start;
  logic [3:0]  start_addr;
  logic [3:0]  start_len;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] ref_mem [16];

  typedef struct {
    int          addr;
    int          len;
    int          mode;   // 0 ready=1, 1 ready 1,0,0 repeating, 2 random, 3 ready=1 + start spam
    logic [31:0] first;
    logic [31:0] lastw;
  } vec_t;

  vec_t vecs [6];

  mem_burst_reader #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_addr    (wr_addr),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .start      (start),
    .start_addr (start_addr),
    .start_len  (start_len),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endfunction

  // Byte-enabled write; updates the reference array with the same lane rule.
  task automatic wr(input int a, input logic [3:0] e, input logic [31:0] d);
    wr_addr = a[3:0];
    wr_en   = e;
    wr_data = d;
    @(negedge clk);
    wr_en = 4'h0;
    for (int i = 0; i < 4; i++)
      if (e[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
  endtask

  // Run one burst starting at a negedge; expected words come from ref_mem.
  task automatic burst(input int a, input int len, input int mode,
                       output logic [31:0] first_w, output logic [31:0] last_w);
    int          n;
    int          got;
    int          cyc;
    bit          done;
    bit          prev_stall;
    logic [31:0] prev_d;
    logic        prev_l;
    logic [31:0] exp_w [16];
    n = (len == 0) ? 16 : len;
    for (int k = 0; k < n; k++) exp_w[k] = ref_mem[(a + k) % 16];
    got = 0; cyc = 0; done = 1'b0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    first_w = '0; last_w = '0;
    start = 1'b1; start_addr = a[3:0]; start_len = len[3:0]; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    while (!done && cyc < 300) begin
      case (mode)
        1:       out_ready = (cyc % 3 == 0);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      if (cyc < 2) check("valid_before_latency", {31'd0, out_valid}, 32'd0);
      if (cyc == 2) check("valid_at_latency", {31'd0, out_valid}, 32'd1);
      if (prev_stall) begin
        check("stall_valid_held", {31'd0, out_valid}, 32'd1);
        check("stall_data_held", out_data, prev_d);
        check("stall_last_held", {31'd0, out_last}, {31'd0, prev_l});
      end
      if (out_valid && out_ready) begin
        if (got < n) begin
          check("word_data", out_data, exp_w[got]);
          check("word_last", {31'd0, out_last}, (got == n - 1) ? 32'd1 : 32'd0);
        end else begin
          check("extra_word", got, n);
        end
        if (got == 0) first_w = out_data;
        last_w = out_data;
        got++;
        if (out_last) done = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_l = out_last;
      if (mode == 3) begin
        start = !done; start_addr = 4'd0; start_len = 4'd2;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("word_count", got, n);
    check("busy_after_last", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] fw;
    logic [31:0] lw;
    logic [31:0] old;
    int          hs;
    int          t;

    vecs[0] = '{addr: 3,  len: 4, mode: 0, first: 32'h1000_0003, lastw: 32'h1000_0006};
    vecs[1] = '{addr: 14, len: 3, mode: 0, first: 32'h1000_000E, lastw: 32'h1000_0000};
    vecs[2] = '{addr: 0,  len: 0, mode: 1, first: 32'h1000_0000, lastw: 32'h1000_000F};
    vecs[3] = '{addr: 15, len: 1, mode: 0, first: 32'h1000_000F, lastw: 32'h1000_000F};
    vecs[4] = '{addr: 7,  len: 0, mode: 2, first: 32'h1000_0007, lastw: 32'h1000_0006};
    vecs[5] = '{addr: 8,  len: 5, mode: 3, first: 32'h1000_0008, lastw: 32'h1000_000C};

    rst = 1'b1; wr_addr = 4'd0; wr_en = 4'h0; wr_data = 32'd0;
    start = 1'b0; start_addr = 4'd0; start_len = 4'd0; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_data", out_data, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) wr(i, 4'hF, 32'h1000_0000 + 32'(i));

    // Directed vector table
    for (int v = 0; v < 6; v++) begin
      burst(vecs[v].addr, vecs[v].len, vecs[v].mode, fw, lw);
      check("vec_first", fw, vecs[v].first);
      check("vec_last", lw, vecs[v].lastw);
    end

    // Partial byte write then single-word burst
    wr(5, 4'b0101, 32'hAABB_CCDD);
    burst(5, 1, 0, fw, lw);
    check("byte_write_word", fw, 32'h10BB_00DD);

    // Write and read of the same word on the same edge returns the old word
    old = ref_mem[9];
    start = 1'b1; start_addr = 4'd9; start_len = 4'd1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr(9, 4'hF, 32'h5555_AAAA);
    @(negedge clk);
    check("rbw_valid", {31'd0, out_valid}, 32'd1);
    check("rbw_data", out_data, old);
    check("rbw_last", {31'd0, out_last}, 32'd1);
    @(negedge clk);
    check("rbw_busy_done", {31'd0, busy}, 32'd0);
    burst(9, 1, 0, fw, lw);
    check("rbw_new_word", fw, 32'h5555_AAAA);

    // Reset in the middle of a len=8 burst
    start = 1'b1; start_addr = 4'd0; start_len = 4'd8; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs = 0; t = 0;
    while (hs < 2 && t < 20) begin
      if (out_valid && out_ready) hs++;
      @(negedge clk);
      t++;
    end
    check("mid_burst_two_words", hs, 2);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_last", {31'd0, out_last}, 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    burst(0, 2, 0, fw, lw);
    check("post_rst_first", fw, 32'h1000_0000);
    check("post_rst_last", lw, 32'h1000_0001);

    // Randomized writes and bursts against the reference array
    for (int r = 0; r < 30; r++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++)
        wr($urandom_range(0, 15), 4'($urandom_range(0, 15)), $urandom);
      burst($urandom_range(0, 15), $urandom_range(0, 15), 2, fw, lw);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
